qec_syndrome_gen: RTL and testbench

- Stimulus source for the 3-qubit repetition-code decoder: produces the syndrome stream that the decoder consumes.
- Encodes a logical bit into a 3-bit repetition codeword and applies an error pattern, either fixed or LFSR-driven.
- Derives the 3-bit syndrome and presents it on a valid/ready interface for a programmed number of frames.
- Keeps frame and injected-error statistics for on-chip self-test.

---
 rtl/qec_syndrome_gen.sv | 165 ++++++++++++++++
 tb/tb_qec_syndrome_gen.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qec_syndrome_gen.sv
// qec_syndrome_gen: stimulus source for the 3-qubit repetition-code decoder.
// Encodes a logical bit into a 3-bit repetition codeword, applies a fixed or
// LFSR-driven error pattern, derives the syndrome and streams it over a
// valid/ready handshake for a programmed number of frames, while counting
// accepted frames and frames that carried an injected error.
module qec_syndrome_gen #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] num_frames,
  input  logic [1:0] err_mode,
  input  logic [2:0] err_pattern,
  input  logic [7:0] err_threshold,
  input  logic       data_in,
  input  logic       synd_ready,
  output logic       synd_valid,
  output logic [2:0] syndrome,
  output logic [2:0] codeword,
  output logic [2:0] err_applied,
  output logic       busy,
  output logic       done,
  output logic [7:0] frames_sent,
  output logic [7:0] errors_injected
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GEN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t     state;
  state_t     state_next;

  logic [7:0] lfsr;
  logic [7:0] lfsr_next;
  logic [7:0] frames_total;

  logic       inject;
  logic [2:0] single_err;
  logic [2:0] err_sel;
  logic [2:0] synd_sel;
  logic       handshake;
  logic       last_frame;

  // Error-pattern selection for the frame being generated from the current LFSR value
  always_comb begin
    inject = (lfsr < err_threshold);
    // Qubit index 3 folds back onto qubit 0.
    case (lfsr[1:0])
      2'b01:   single_err = 3'b010;
      2'b10:   single_err = 3'b100;
      default: single_err = 3'b001;
    endcase
    case (err_mode)
      2'b00:   err_sel = '0;
      2'b01:   err_sel = err_pattern;
      2'b10:   err_sel = inject ? single_err : 3'b000;
      default: err_sel = inject ? lfsr[2:0] : 3'b000;
    endcase
  end

  // Syndrome lookup: single-qubit errors map to distinct codes, anything heavier saturates
  always_comb begin
    case (err_sel)
      3'b000:  synd_sel = 3'b000;
      3'b001:  synd_sel = 3'b011;
      3'b010:  synd_sel = 3'b010;
      3'b100:  synd_sel = 3'b001;
      default: synd_sel = 3'b111;
    endcase
  end

  // LFSR successor and run-progress helpers
  always_comb begin
    lfsr_next  = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    handshake  = (state == HOLD) && synd_ready;
    last_frame = ((frames_sent + 8'd1) == frames_total);
  end

  // Next-state logic and state-decoded outputs
  always_comb begin
    state_next = state;
    synd_valid = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (num_frames != 8'd0) ? GEN : DONE;
        end
      end
      GEN: begin
        busy       = 1'b1;
        state_next = HOLD;
      end
      HOLD: begin
        busy       = 1'b1;
        synd_valid = 1'b1;
        if (handshake) begin
          state_next = last_frame ? DONE : GEN;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath: run setup, frame registration, LFSR stepping and statistics
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr            <= SEED;
      frames_total    <= '0;
      syndrome        <= '0;
      codeword        <= '0;
      err_applied     <= '0;
      frames_sent     <= '0;
      errors_injected <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            frames_sent     <= '0;
            errors_injected <= '0;
            if (num_frames != 8'd0) begin
              frames_total <= num_frames;
              lfsr         <= SEED;
            end
          end
        end
        GEN: begin
          err_applied <= err_sel;
          codeword    <= {3{data_in}} ^ err_sel;
          syndrome    <= synd_sel;
          lfsr        <= lfsr_next;
        end
        HOLD: begin
          if (handshake) begin
            frames_sent <= frames_sent + 8'd1;
            if (err_applied != 3'b000) begin
              errors_injected <= errors_injected + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_qec_syndrome_gen.sv
// Testbench for qec_syndrome_gen: randomized runs checked cycle by cycle
// against a transaction-level reference model of the syndrome generator.
module tb_qec_syndrome_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] num_frames;
  logic [1:0] err_mode;
  logic [2:0] err_pattern;
  logic [7:0] err_threshold;
  logic       data_in;
  logic       synd_ready;
  logic       synd_valid;
  logic [2:0] syndrome;
  logic [2:0] codeword;
  logic [2:0] err_applied;
  logic       busy;
  logic       done;
  logic [7:0] frames_sent;
  logic [7:0] errors_injected;

  int unsigned checks = 0;
  int unsigned passed = 0;

  // Run configuration used by run_frames
  logic [1:0]  cfg_mode;
  logic [2:0]  cfg_pat;
  logic [7:0]  cfg_thr;
  logic        cfg_data;
  bit          cfg_random;
  int unsigned cfg_stall_min;
  int unsigned cfg_stall_max;

  qec_syndrome_gen #(.SEED(8'hA5)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .num_frames     (num_frames),
    .err_mode       (err_mode),
    .err_pattern    (err_pattern),
    .err_threshold  (err_threshold),
    .data_in        (data_in),
    .synd_ready     (synd_ready),
    .synd_valid     (synd_valid),
    .syndrome       (syndrome),
    .codeword       (codeword),
    .err_applied    (err_applied),
    .busy           (busy),
    .done           (done),
    .frames_sent    (frames_sent),
    .errors_injected(errors_injected)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [2:0] model_err(input logic [1:0] m, input logic [2:0] p,
                                           input logic [7:0] l, input logic [7:0] t);
    int unsigned q;
    if (m == 2'd0) return 3'b000;
    if (m == 2'd1) return p;
    if (int'(l) >= int'(t)) return 3'b000;
    if (m == 2'd2) begin
      q = int'(l) % 4;
      if (q == 3) q = 0;
      return 3'(1 << q);
    end
    return 3'(int'(l) % 8);
  endfunction

  function automatic logic [2:0] model_syn(input logic [2:0] e);
    if ($countones(e) >= 2) return 3'b111;
    if (e == 3'b001) return 3'b011;
    if (e == 3'b010) return 3'b010;
    if (e == 3'b100) return 3'b001;
    return 3'b000;
  endfunction

  function automatic logic [7:0] model_lfsr(input logic [7:0] l);
    int unsigned fb;
    fb = (int'(l[7]) + int'(l[5]) + int'(l[4]) + int'(l[3])) % 2;
    return 8'((int'(l) * 2 + fb) % 256);
  endfunction

  function automatic logic [18:0] obs_ctl();
    return {synd_valid, busy, done, frames_sent, errors_injected};
  endfunction

  function automatic logic [27:0] obs_all();
    return {synd_valid, busy, done, syndrome, codeword, err_applied, frames_sent, errors_injected};
  endfunction

  // Runs one start..done sequence of nf frames and checks every cycle of it
  task automatic run_frames(input string name, input int unsigned nf);
    logic [7:0]  l;
    logic [2:0]  e, syn, cw, p;
    logic [1:0]  m;
    logic [7:0]  t;
    logic        d;
    logic [18:0] exp_ctl;
    logic [27:0] exp_all;
    int unsigned sent, inj, k;
    start      = 1'b1;
    num_frames = 8'(nf);
    step();
    start      = 1'b0;
    num_frames = 8'($urandom);
    sent = 0;
    inj  = 0;
    l    = 8'hA5;
    for (int unsigned f = 0; f < nf; f++) begin
      exp_ctl = {1'b0, 1'b1, 1'b0, 8'(sent), 8'(inj)};
      checks++;
      if (obs_ctl() !== exp_ctl)
        $display("FAIL %s gen f%0d: got %h want %h", name, f, obs_ctl(), exp_ctl);
      else passed++;
      if (cfg_random) begin
        m = 2'($urandom); p = 3'($urandom); t = 8'($urandom); d = 1'($urandom);
      end else begin
        m = cfg_mode; p = cfg_pat; t = cfg_thr; d = cfg_data;
      end
      err_mode = m; err_pattern = p; err_threshold = t; data_in = d;
      synd_ready = 1'($urandom);
      e   = model_err(m, p, l, t);
      syn = model_syn(e);
      cw  = {3{d}} ^ e;
      l   = model_lfsr(l);
      step();
      exp_all = {1'b1, 1'b1, 1'b0, syn, cw, e, 8'(sent), 8'(inj)};
      k = $urandom_range(cfg_stall_max, cfg_stall_min);
      for (int unsigned s = 0; s < k; s++) begin
        synd_ready    = 1'b0;
        err_mode      = 2'($urandom);
        err_pattern   = 3'($urandom);
        err_threshold = 8'($urandom);
        data_in       = 1'($urandom);
        start         = 1'($urandom);
        num_frames    = 8'($urandom);
        checks++;
        if (obs_all() !== exp_all)
          $display("FAIL %s stall f%0d s%0d: got %h want %h", name, f, s, obs_all(), exp_all);
        else passed++;
        step();
      end
      synd_ready = 1'b1;
      start      = 1'b0;
      checks++;
      if (obs_all() !== exp_all)
        $display("FAIL %s hold f%0d: got %h want %h", name, f, obs_all(), exp_all);
      else passed++;
      step();
      sent++;
      if (e != 3'b000) inj++;
    end
    exp_ctl = {1'b0, 1'b0, 1'b1, 8'(sent), 8'(inj)};
    checks++;
    if (obs_ctl() !== exp_ctl)
      $display("FAIL %s done: got %h want %h", name, obs_ctl(), exp_ctl);
    else passed++;
    step();
    exp_ctl = {1'b0, 1'b0, 1'b0, 8'(sent), 8'(inj)};
    checks++;
    if (obs_ctl() !== exp_ctl)
      $display("FAIL %s idle_after: got %h want %h", name, obs_ctl(), exp_ctl);
    else passed++;
  endtask

  task automatic set_cfg(input logic [1:0] m, input logic [2:0] p, input logic [7:0] t,
                         input logic d, input bit rnd, input int unsigned smin,
                         input int unsigned smax);
    cfg_mode = m; cfg_pat = p; cfg_thr = t; cfg_data = d;
    cfg_random = rnd; cfg_stall_min = smin; cfg_stall_max = smax;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++;
    if (obs_all() !== 28'd0) $display("FAIL reset_state: got %h want %h", obs_all(), 28'd0);
    else passed++;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (obs_all() !== 28'd0) $display("FAIL reset_idle: got %h want %h", obs_all(), 28'd0);
    else passed++;
  endtask

  task automatic test_zero_frames();
    set_cfg(2'd1, 3'b111, 8'h00, 1'b0, 1'b0, 0, 0);
    run_frames("zero_frames", 0);
  endtask

  task automatic test_fixed();
    set_cfg(2'd1, 3'b010, 8'h00, 1'b1, 1'b0, 0, 0);
    run_frames("fixed", 3);
    checks++;
    if ({syndrome, codeword} !== {3'b010, 3'b101})
      $display("FAIL fixed_last_frame: got %b_%b want 010_101", syndrome, codeword);
    else passed++;
  endtask

  task automatic test_random_single();
    set_cfg(2'd2, 3'b000, 8'hFF, 1'b0, 1'b0, 0, 1);
    run_frames("rand_single", 2);
    checks++;
    if ({syndrome, err_applied} !== {3'b001, 3'b100})
      $display("FAIL rand_single_frame2: got %b_%b want 001_100", syndrome, err_applied);
    else passed++;
  endtask

  task automatic test_threshold_zero();
    set_cfg(2'd2, 3'b000, 8'h00, 1'b1, 1'b0, 0, 2);
    run_frames("thr_zero_m2", 4);
    set_cfg(2'd3, 3'b000, 8'h00, 1'b0, 1'b0, 0, 2);
    run_frames("thr_zero_m3", 4);
  endtask

  task automatic test_weight2();
    set_cfg(2'd3, 3'b000, 8'hFF, 1'b1, 1'b0, 0, 0);
    run_frames("weight2", 1);
    checks++;
    if (syndrome !== 3'b111) $display("FAIL weight2_syndrome: got %b want 111", syndrome);
    else passed++;
  endtask

  task automatic test_stall();
    set_cfg(2'd3, 3'b000, 8'hFF, 1'b0, 1'b0, 5, 5);
    run_frames("stall", 3);
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 6; r++) begin
      set_cfg(2'd0, 3'b000, 8'h00, 1'b0, 1'b1, 0, 3);
      run_frames("random_run", $urandom_range(20, 1));
    end
  endtask

  task automatic test_reset_midrun();
    err_mode = 2'd1; err_pattern = 3'b111; data_in = 1'b1; synd_ready = 1'b0;
    start = 1'b1; num_frames = 8'd5;
    step();
    start = 1'b0;
    step();
    checks++;
    if (synd_valid !== 1'b1) $display("FAIL midrun_valid: got %b want 1", synd_valid);
    else passed++;
    rst_n = 1'b0;
    start = 1'b1;
    step();
    checks++;
    if (obs_all() !== 28'd0) $display("FAIL midrun_reset: got %h want %h", obs_all(), 28'd0);
    else passed++;
    rst_n = 1'b1;
    start = 1'b0;
    step();
    checks++;
    if (obs_all() !== 28'd0) $display("FAIL midrun_after: got %h want %h", obs_all(), 28'd0);
    else passed++;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; num_frames = '0; err_mode = '0; err_pattern = '0;
    err_threshold = '0; data_in = 1'b0; synd_ready = 1'b0;
    test_reset();
    test_zero_frames();
    test_fixed();
    test_random_single();
    test_threshold_zero();
    test_weight2();
    test_stall();
    test_back_to_back();
    test_reset_midrun();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
